// File: rtl/pw_hash_check.sv
// Password frame checker: CRC-16/0x1021 over WORDS store words, compared to target.
// Define PW_HASH_TIMEOUT_EN to abort frames after TIMEOUT idle cycles.
module pw_hash_check #(
    parameter int WORDS   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        store_valid,
    input  logic [15:0] store_data,
    input  logic [15:0] target,
    input  logic        clear_flags,
    input  logic        result_ready,
    output logic        result_valid,
    output logic [15:0] result_hash,
    output logic        result_match,
    output logic        busy,
    output logic        overflow,
    output logic        timeout_err
);

    if (WORDS < 1 || WORDS > 255) begin : g_bad_words
        $error("pw_hash_check: WORDS out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("pw_hash_check: TIMEOUT out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [7:0] LAST = 8'(WORDS);

    state_t      state, state_nx;
    logic [7:0]  count, count_nx;
    logic [15:0] crc, crc_nx;
    logic [15:0] crc_base, crc_new;
    logic [7:0]  count_new;
    logic        valid_nx, match_nx;
    logic [15:0] hash_nx;
    logic        absorb;
    logic        ovf_set;
    logic        ovf_nx;

    function automatic logic [15:0] crc_word(
        input logic [15:0] c,
        input logic [15:0] w
    );
        logic [15:0] r;
        r = c ^ w;
        for (int i = 0; i < 16; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    // A word seen outside ACCUM always starts a fresh frame.
    assign crc_base  = (state == ACCUM) ? crc : 16'hFFFF;
    assign crc_new   = crc_word(crc_base, store_data);
    assign count_new = (state == ACCUM) ? count + 8'd1 : 8'd1;

`ifdef PW_HASH_TIMEOUT_EN
    localparam logic [15:0] GAP_LAST = 16'(TIMEOUT - 1);
    logic [15:0] gap, gap_nx;
    logic        tmo_set;
    logic        tmo_nx;
`endif

    always_comb begin
        state_nx = state;
        count_nx = count;
        crc_nx   = crc;
        valid_nx = result_valid;
        hash_nx  = result_hash;
        match_nx = result_match;
        absorb   = 1'b0;
        ovf_set  = 1'b0;
`ifdef PW_HASH_TIMEOUT_EN
        gap_nx   = gap;
        tmo_set  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                absorb = store_valid;
            end
            ACCUM: begin
                absorb = store_valid;
`ifdef PW_HASH_TIMEOUT_EN
                if (!store_valid) begin
                    if (gap == GAP_LAST) begin
                        state_nx = IDLE;
                        count_nx = 8'd0;
                        crc_nx   = 16'hFFFF;
                        gap_nx   = 16'd0;
                        tmo_set  = 1'b1;
                    end else begin
                        gap_nx = gap + 16'd1;
                    end
                end
`endif
            end
            DONE: begin
                if (result_ready) begin
                    valid_nx = 1'b0;
                    if (store_valid) begin
                        absorb = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        count_nx = 8'd0;
                        crc_nx   = 16'hFFFF;
                    end
                end else if (store_valid) begin
                    ovf_set = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                count_nx = 8'd0;
                crc_nx   = 16'hFFFF;
            end
        endcase

        if (absorb) begin
            crc_nx   = crc_new;
            count_nx = count_new;
`ifdef PW_HASH_TIMEOUT_EN
            gap_nx   = 16'd0;
`endif
            if (count_new == LAST) begin
                state_nx = DONE;
                valid_nx = 1'b1;
                hash_nx  = crc_new;
                match_nx = (crc_new == target);
            end else begin
                state_nx = ACCUM;
            end
        end
    end

    // Set wins over clear on the sticky flag.
    assign ovf_nx = ovf_set | (overflow & ~clear_flags);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= 8'd0;
            crc          <= 16'hFFFF;
            result_valid <= 1'b0;
            result_hash  <= 16'd0;
            result_match <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nx;
            count        <= count_nx;
            crc          <= crc_nx;
            result_valid <= valid_nx;
            result_hash  <= hash_nx;
            result_match <= match_nx;
            overflow     <= ovf_nx;
        end
    end

    assign busy = (state != IDLE);

`ifdef PW_HASH_TIMEOUT_EN
    assign tmo_nx = tmo_set | (timeout_err & ~clear_flags);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap         <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            gap         <= gap_nx;
            timeout_err <= tmo_nx;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pw_hash_check.sv
// Randomized + directed bench for pw_hash_check against a frame-level model.
// Follows PW_HASH_TIMEOUT_EN the same way the design does.
module tb_pw_hash_check;

    localparam int WORDS   = 4;
    localparam int TIMEOUT = 16;
`ifdef PW_HASH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        store_valid = 1'b0;
    logic [15:0] store_data = 16'd0;
    logic [15:0] target = 16'd0;
    logic        clear_flags = 1'b0;
    logic        result_ready = 1'b0;
    logic        result_valid;
    logic [15:0] result_hash;
    logic        result_match;
    logic        busy;
    logic        overflow;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    pw_hash_check #(.WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .store_valid(store_valid),
        .store_data(store_data),
        .target(target),
        .clear_flags(clear_flags),
        .result_ready(result_ready),
        .result_valid(result_valid),
        .result_hash(result_hash),
        .result_match(result_match),
        .busy(busy),
        .overflow(overflow),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Bit-serial CRC: feed data bits MSB first into the feedback.
    function automatic logic [15:0] ref_crc(input logic [15:0] c,
                                            input logic [15:0] d);
        bit fb;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Frame-level model
    logic [15:0] m_crc, m_hash;
    int          m_n, m_gap;
    bit          m_inf, m_valid, m_match, m_ovf, m_tmo;

    task automatic model_step();
        bit so, st, take;
        if (reset) begin
            m_crc = 16'hFFFF; m_hash = 16'd0; m_n = 0; m_gap = 0;
            m_inf = 0; m_valid = 0; m_match = 0; m_ovf = 0; m_tmo = 0;
            return;
        end
        so = 0; st = 0; take = 0;
        if (m_valid) begin
            if (result_ready) begin
                m_valid = 0;
                take = store_valid;
            end else if (store_valid) begin
                so = 1;
            end
        end else if (store_valid) begin
            take = 1;
        end else if (m_inf) begin
            m_gap++;
            if (TMO_EN && m_gap == TIMEOUT) begin
                m_inf = 0; m_gap = 0; st = 1;
            end
        end
        if (take) begin
            if (!m_inf) begin
                m_crc = 16'hFFFF; m_n = 0;
            end
            m_crc = ref_crc(m_crc, store_data);
            m_n++;
            m_gap = 0;
            m_inf = 1;
            if (m_n == WORDS) begin
                m_valid = 1; m_hash = m_crc;
                m_match = (m_crc == target); m_inf = 0;
            end
        end
        m_ovf = so | (m_ovf & !clear_flags);
        m_tmo = st | (m_tmo & !clear_flags);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            model_step();
            if (!reset) started = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started || reset) begin
                chk("valid", {15'd0, result_valid}, {15'd0, m_valid});
                chk("busy", {15'd0, busy}, {15'd0, m_inf | m_valid});
                chk("overflow", {15'd0, overflow}, {15'd0, m_ovf});
                chk("timeout_err", {15'd0, timeout_err}, {15'd0, m_tmo});
                chk("hash", result_hash, m_hash);
                chk("match", {15'd0, result_match}, {15'd0, m_match});
            end
        end
    end

    task automatic drive(input bit v, input logic [15:0] d, input bit rdy);
        @(negedge clk);
        store_valid = v;
        store_data = d;
        result_ready = rdy;
    endtask

    task automatic frame(input logic [15:0] w3, input bit rdy);
        drive(1, 16'hFFFF, rdy);
        drive(1, 16'h0000, rdy);
        drive(1, 16'h0000, rdy);
        drive(1, w3, rdy);
        drive(0, 16'h0000, rdy);
    endtask

    initial begin
        logic [15:0] pick [4];
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // zero frame, matching target
        target = 16'h0000;
        frame(16'h0000, 1);
        chk("d32_valid", {15'd0, result_valid}, 16'd1);
        chk("d32_hash", result_hash, 16'h0000);
        chk("d32_match", {15'd0, result_match}, 16'd1);
        drive(0, 16'h0000, 1);

        // same frame, other target
        target = 16'h1234;
        frame(16'h0000, 1);
        chk("d33_hash", result_hash, 16'h0000);
        chk("d33_match", {15'd0, result_match}, 16'd0);
        drive(0, 16'h0000, 1);

        // last word 1 -> x^16 mod poly
        target = 16'h1021;
        frame(16'h0001, 1);
        chk("pin_hash", result_hash, 16'h1021);
        chk("pin_match", {15'd0, result_match}, 16'd1);
        drive(0, 16'h0000, 1);

        // held result, overflow, clear
        target = 16'h0000;
        frame(16'h0000, 0);
        drive(0, 16'h0000, 0);
        drive(1, 16'hABCD, 0);
        drive(0, 16'h0000, 0);
        chk("d34_ovf", {15'd0, overflow}, 16'd1);
        drive(0, 16'h0000, 0);
        drive(0, 16'h0000, 0);
        chk("d34_held_valid", {15'd0, result_valid}, 16'd1);
        chk("d34_held_hash", result_hash, 16'h0000);
        @(negedge clk) clear_flags = 1'b1;
        @(negedge clk) clear_flags = 1'b0;
        chk("d34_clr", {15'd0, overflow}, 16'd0);
        drive(0, 16'h0000, 1);
        drive(0, 16'h0000, 1);
        chk("d34_idle", {15'd0, busy}, 16'd0);

        // retire and start next frame in one cycle
        frame(16'h0000, 0);
        drive(1, 16'hFFFF, 1);
        drive(1, 16'h0000, 1);
        chk("d35_drop", {15'd0, result_valid}, 16'd0);
        chk("d35_busy", {15'd0, busy}, 16'd1);
        drive(1, 16'h0000, 1);
        drive(1, 16'h0000, 1);
        drive(0, 16'h0000, 1);
        chk("d35_valid", {15'd0, result_valid}, 16'd1);
        chk("d35_hash", result_hash, 16'h0000);
        chk("d35_ovf", {15'd0, overflow}, 16'd0);
        drive(0, 16'h0000, 1);

        // gap timeout
        drive(1, 16'hFFFF, 1);
        drive(1, 16'h0000, 1);
        repeat (17) drive(0, 16'h0000, 1);
        chk("d36_busy", {15'd0, busy}, {15'd0, !TMO_EN});
        chk("d36_tmo", {15'd0, timeout_err}, {15'd0, TMO_EN});
        chk("d36_valid", {15'd0, result_valid}, 16'd0);
        if (!TMO_EN) begin
            drive(1, 16'h0000, 1);
            drive(1, 16'h0000, 1);
            drive(0, 16'h0000, 1);
        end
        @(negedge clk) clear_flags = 1'b1;
        @(negedge clk) clear_flags = 1'b0;

        // reset mid-frame
        drive(1, 16'hFFFF, 1);
        drive(1, 16'h0000, 1);
        @(negedge clk);
        store_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("d37_valid", {15'd0, result_valid}, 16'd0);
        chk("d37_busy", {15'd0, busy}, 16'd0);
        chk("d37_hash", result_hash, 16'h0000);
        @(negedge clk) reset = 1'b0;
        frame(16'h0000, 1);
        chk("d37_res", {15'd0, result_valid}, 16'd1);
        chk("d37_rhash", result_hash, 16'h0000);
        drive(0, 16'h0000, 1);
        chk("d37_single", {15'd0, result_valid}, 16'd0);

        // random traffic
        pick[0] = 16'h0000; pick[1] = 16'hFFFF;
        pick[2] = 16'h1021; pick[3] = 16'h8000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                repeat (TIMEOUT + 3) begin
                    @(negedge clk);
                    store_valid = 1'b0;
                    clear_flags = 1'b0;
                    result_ready = $urandom_range(0, 1);
                end
            end
            @(negedge clk);
            store_valid = ($urandom_range(0, 99) < 60);
            store_data = ($urandom_range(0, 1) != 0) ?
                         pick[$urandom_range(0, 3)] : 16'($urandom);
            target = ($urandom_range(0, 1) != 0) ?
                     pick[$urandom_range(0, 3)] : 16'($urandom);
            result_ready = ($urandom_range(0, 99) < 60);
            clear_flags = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 999) < 3) begin
                reset = 1'b1;
                @(negedge clk) reset = 1'b0;
            end
        end
        @(negedge clk);
        store_valid = 1'b0;
        clear_flags = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
